// File: rtl/oam_dma_arbiter_if.sv
// CPU-side and system-bus-side signals of the sprite DMA arbiter.
// slave: the arbiter; master: the CPU core / bus fabric that surrounds it.
interface oam_dma_arbiter_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_r_nw;
  logic [7:0]  bus_din;
  logic [15:0] bus_addr;
  logic [7:0]  bus_dout;
  logic        bus_r_nw;
  logic        cpu_rdy;
  logic        dma_active;

  modport slave (
    input  cpu_addr, cpu_dout, cpu_r_nw, bus_din,
    output bus_addr, bus_dout, bus_r_nw, cpu_rdy, dma_active
  );

  modport master (
    output cpu_addr, cpu_dout, cpu_r_nw, bus_din,
    input  bus_addr, bus_dout, bus_r_nw, cpu_rdy, dma_active
  );
endinterface

// File: rtl/oam_dma_arbiter.sv
// Sprite DMA + bus arbiter: $4014 write halts CPU (cpu_rdy) and copies 256 bytes to $2004; 514/515-cycle stall.
// Outputs combinational from state; CPU stalls only on its reads. OAM_DMA_DBG_EN adds idx/state/stall-count debug ports.
module oam_dma_arbiter #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic            clk_ph1,
  input  logic            rst,
  oam_dma_arbiter_if.slave io
`ifdef OAM_DMA_DBG_EN
  ,
  output logic [7:0]      dma_idx_dbg,
  output logic [2:0]      dma_state_dbg,
  output logic [15:0]     dma_stall_cnt_dbg
`endif
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  page;
  logic [7:0]  idx;
  logic [7:0]  data_buf;
  logic        phase;
  logic        trigger;

  assign trigger = !io.cpu_r_nw && (io.cpu_addr == DMA_REG_ADDR);

  always_ff @(posedge clk_ph1) begin
    if (rst) begin
      state    <= IDLE;
      page     <= 8'h00;
      idx      <= 8'h00;
      data_buf <= 8'h00;
      phase    <= 1'b0;
    end else begin
      state <= state_nxt;
      phase <= ~phase;
      // page only loads from IDLE; a repeat $4014 write during HALT is ignored
      if (state == IDLE && trigger) begin
        page <= io.cpu_dout;
        idx  <= 8'h00;
      end
      if (state == READ) begin
        data_buf <= io.bus_din;
      end
      if (state == WRITE) begin
        idx <= idx + 8'h01;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    io.bus_addr   = io.cpu_addr;
    io.bus_dout   = io.cpu_dout;
    io.bus_r_nw   = io.cpu_r_nw;
    io.cpu_rdy    = 1'b1;
    io.dma_active = 1'b0;
    case (state)
      IDLE: begin
        if (trigger) state_nxt = HALT;
      end
      HALT: begin
        io.cpu_rdy = 1'b0;
        if (io.cpu_r_nw) state_nxt = ALIGN;
      end
      ALIGN: begin
        io.cpu_rdy    = 1'b0;
        io.dma_active = 1'b1;
        if (phase) state_nxt = READ;
      end
      READ: begin
        io.cpu_rdy    = 1'b0;
        io.dma_active = 1'b1;
        io.bus_addr   = {page, idx};
        io.bus_r_nw   = 1'b1;
        io.bus_dout   = data_buf;
        state_nxt     = WRITE;
      end
      WRITE: begin
        io.cpu_rdy    = 1'b0;
        io.dma_active = 1'b1;
        io.bus_addr   = OAM_DATA_ADDR;
        io.bus_r_nw   = 1'b0;
        io.bus_dout   = data_buf;
        state_nxt     = (idx == 8'hFF) ? IDLE : READ;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

`ifdef OAM_DMA_DBG_EN
  logic [15:0] stall_cnt;

  always_ff @(posedge clk_ph1) begin
    if (rst) begin
      stall_cnt <= 16'h0000;
    end else if (!io.cpu_rdy && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'h0001;
    end
  end

  assign dma_idx_dbg       = idx;
  assign dma_state_dbg     = state;
  assign dma_stall_cnt_dbg = stall_cnt;
`endif

endmodule

// File: doc/oam_dma_arbiter.md
Name: oam_dma_arbiter

Overview:
Sprite DMA controller and bus arbiter that sits between the CPU core and the system bus. A CPU write to $4014 latches a source page, halts the CPU through cpu_rdy, and takes ownership of the bus. It then copies 256 bytes from {page, 8'h00..8'hFF} to the PPU OAM data port, one read/write pair at a time. When the copy completes, bus ownership returns to the CPU.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU write address that triggers DMA.
- OAM_DATA_ADDR, 16'h2004, destination address written once per byte.

Ports:
- clk_ph1  in  1  system clock; single clock, all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_addr  in  16  CPU address bus.
- cpu_dout  in  8  CPU write data.
- cpu_r_nw  in  1  CPU read/not-write.
- bus_din  in  8  read data returned from the system bus.
- bus_addr  out  16  arbitrated system address.
- bus_dout  out  8  arbitrated write data.
- bus_r_nw  out  1  arbitrated read/not-write.
- cpu_rdy  out  1  1 = CPU may advance; 0 = CPU must hold on its current read.
- dma_active  out  1  1 while the DMA owns the bus (ALIGN, READ and WRITE states).

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, page=0, idx=0, data_buf=0, phase=0.
  - Outputs: cpu_rdy=1, dma_active=0, bus pass-through.
- phase: free-running 1-bit toggle every clock, 0 after reset. It marks get/put cycle parity.
- Outputs are combinational from state. In IDLE, HALT and ALIGN:
  - bus_addr=cpu_addr, bus_dout=cpu_dout, bus_r_nw=cpu_r_nw.
- IDLE:
  - cpu_rdy=1.
  - On an edge with cpu_r_nw=0 and cpu_addr==DMA_REG_ADDR: page<=cpu_dout, idx<=0, state<=HALT.
- HALT:
  - cpu_rdy=0.
  - CPU writes still pass through. The CPU only halts on a read, so up to 3 consecutive writes complete here.
  - Further writes to DMA_REG_ADDR in HALT are ignored; page is not reloaded.
  - On an edge with cpu_r_nw=1: state<=ALIGN. That read cycle is the halt dummy cycle; its data is discarded by the CPU.
- ALIGN:
  - cpu_rdy=0, dma_active=1.
  - Bus carries the CPU's held read (dummy).
  - On an edge with phase=1: state<=READ. Otherwise stay in ALIGN.
  - ALIGN therefore lasts 1 or 2 cycles, and READ always begins on phase=0.
- READ:
  - bus_addr={page, idx}, bus_r_nw=1, bus_dout=data_buf.
  - At the edge: data_buf<=bus_din, state<=WRITE.
- WRITE:
  - bus_addr=OAM_DATA_ADDR, bus_r_nw=0, bus_dout=data_buf.
  - At the edge: idx<=idx+1 (8-bit wrap).
  - If idx was 8'hFF: state<=IDLE. Otherwise state<=READ.
- Address arithmetic: the source address never carries into the high byte. Page 8'hFF reads $FF00..$FFFF, then stops.
- Latency:
  - Trigger edge to first READ cycle = HALT cycles (≥1) + ALIGN cycles (1–2).
  - READ/WRITE section is exactly 512 cycles.
  - With the CPU immediately on a read after the trigger, the stall is 514 cycles (even alignment) or 515 cycles (odd alignment).
- cpu_rdy returns to 1 in the first cycle after the final WRITE. The CPU's held read then re-executes with normal data.
- Reset mid-transfer: abort immediately. Next cycle is IDLE with pass-through and cpu_rdy=1. Partial OAM contents stay as written.
- No input is ignored in IDLE except non-matching addresses. A read of DMA_REG_ADDR does not trigger.

Optional Feature:
- Macro: OAM_DMA_DBG_EN.
- When defined, adds three outputs in line with the CPU's *_dbg convention:
  - dma_idx_dbg [7:0] = idx.
  - dma_state_dbg [2:0] = state encoding: IDLE=0, HALT=1, ALIGN=2, READ=3, WRITE=4.
  - dma_stall_cnt_dbg [15:0] = count of cycles with cpu_rdy=0 since reset. It saturates at 16'hFFFF and clears only on rst.
- When undefined, these ports and the counter do not exist, and functional behaviour is identical.

Test Plan:
- Basic transfer:
  - Stimulus: CPU writes 8'h02 to $4014, next cycle is a read, phase=1 at the ALIGN edge; memory $0200+i = i^8'h5A.
  - Required: 256 writes to $2004 with data i^8'h5A in order; cpu_rdy low for exactly 514 cycles; bus_addr alternates $02ii/$2004.
- Odd alignment:
  - Stimulus: same as basic transfer, but phase=0 at the first ALIGN edge.
  - Required: ALIGN lasts 2 cycles; cpu_rdy low for exactly 515 cycles; the first READ occurs on phase=0.
- Trigger followed by writes (models an interrupt push):
  - Stimulus: trigger followed by 3 CPU write cycles, including one to $4014 with 8'h07.
  - Required: all 3 writes appear on the bus unchanged; page stays 8'h02; DMA starts only after the first CPU read.
- Page wrap:
  - Stimulus: write 8'hFF to $4014.
  - Required: last source address is $FFFF; no access to $0000; state returns to IDLE.
- Reset mid-transfer:
  - Stimulus: assert rst for 1 cycle during READ with idx=8'h40.
  - Required: next cycle cpu_rdy=1 and dma_active=0; bus follows cpu_addr; no further $2004 writes occur.
- Non-triggers:
  - Stimulus: a CPU read of $4014, and a write to $4015.
  - Required: no state change; cpu_rdy stays 1.
